// File: rtl/noc_merge_arbiter2.sv
// noc_merge_arbiter2: 2-to-1 round-robin flit merge into a one-entry output register (optional grant counters via ARB_STATS_EN)
module noc_merge_arbiter2 #(
  parameter int W = 9,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic [W-1:0]      in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [W-1:0]      in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              out_sel,
  input  logic              out_ready,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
);
  logic last_grant;
  logic load_en;
  logic grant;
  // register can take a flit when empty or draining; contention alternates away from the last winner
  always_comb begin
    load_en   = !out_valid || out_ready;
    grant     = (in0_valid && in1_valid) ? ~last_grant : in1_valid;
    in0_ready = !reset && load_en && !grant && in0_valid;
    in1_ready = !reset && load_en && grant && in1_valid;
  end
  // output register; priority pointer rotates only on an accepted flit
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 1'b0;
      last_grant <= 1'b1;
    end else if (load_en) begin
      out_valid <= in0_ready || in1_ready;
      if (in0_ready || in1_ready) begin
        out_data   <= grant ? in1_data : in0_data;
        out_sel    <= grant;
        last_grant <= grant;
      end
    end
  end
`ifdef ARB_STATS_EN
  // saturating per-source counts of forwarded flits
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (in0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (in1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_noc_merge_arbiter2.sv
// tb_noc_merge_arbiter2: directed self-checking bench for the 2-to-1 round-robin merge
module tb_noc_merge_arbiter2;
  logic clk = 1'b0;
  logic reset;
  logic in0_valid, in1_valid, in0_ready, in1_ready;
  logic [8:0] in0_data, in1_data, out_data;
  logic out_valid, out_sel, out_ready;
  logic [15:0] grant_cnt0, grant_cnt1;
  int total = 0;
  int passed = 0;
  logic [8:0] seq [3];

  noc_merge_arbiter2 #(.W(9), .STAT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string tag, input logic v, input logic [8:0] d, input logic s);
    check({tag, "_valid"}, out_valid, v);
    check({tag, "_data"}, out_data, d);
    check({tag, "_sel"}, out_sel, s);
  endtask

  task automatic rdy_is(input string tag, input logic r0, input logic r1);
    #1;
    check({tag, "_rdy0"}, in0_ready, r0);
    check({tag, "_rdy1"}, in1_ready, r1);
  endtask

  initial begin
    seq[0] = 9'h0F3; seq[1] = 9'h121; seq[2] = 9'h1FF;
    reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; out_ready = 1'b0;
    cyc(); cyc();
    out_is("rst", 1'b0, 9'h000, 1'b0);
    in0_valid = 1'b1; in0_data = 9'h1A5;
    rdy_is("rst_cycle", 1'b0, 1'b0);
    reset = 1'b0;
    rdy_is("midload", 1'b1, 1'b0);
    cyc();
    in0_valid = 1'b0;
    out_is("midload", 1'b1, 9'h1A5, 1'b0);
    cyc();
    out_is("midhold", 1'b1, 9'h1A5, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    out_is("midrst", 1'b0, 9'h000, 1'b0);
    in0_valid = 1'b1; in0_data = 9'h011;
    in1_valid = 1'b1; in1_data = 9'h1E2;
    out_ready = 1'b1;
    rdy_is("postrst", 1'b1, 1'b0);
    cyc();
    out_is("postrst", 1'b1, 9'h011, 1'b0);
    in1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0_data = seq[i];
      rdy_is("single", 1'b1, 1'b0);
      cyc();
      out_is("single", 1'b1, seq[i], 1'b0);
    end
    in0_valid = 1'b0;
    cyc();
    check("single_drain", out_valid, 1'b0);
    in1_valid = 1'b1; in1_data = 9'h155;
    rdy_is("solo1", 1'b0, 1'b1);
    cyc();
    out_is("solo1", 1'b1, 9'h155, 1'b1);
    in0_valid = 1'b1; in0_data = 9'h011; in1_data = 9'h1E2;
    for (int i = 0; i < 6; i++) begin
      rdy_is("cont", i % 2 == 0, i % 2 == 1);
      cyc();
      out_is("cont", 1'b1, (i % 2 == 0) ? 9'h011 : 9'h1E2, i % 2 == 1);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdy_is("stall", 1'b0, 1'b0);
      cyc();
      out_is("stall", 1'b1, 9'h1E2, 1'b1);
    end
    out_ready = 1'b1;
    rdy_is("release", 1'b1, 1'b0);
    cyc();
    out_is("release", 1'b1, 9'h011, 1'b0);
    in0_valid = 1'b0;
    in1_data = 9'h0AA;
    rdy_is("idle_w1", 1'b0, 1'b1);
    cyc();
    out_is("idle_w1", 1'b1, 9'h0AA, 1'b1);
    in1_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check("idle_empty", out_valid, 1'b0);
    in0_valid = 1'b1; in1_valid = 1'b1;
    rdy_is("idle_hold", 1'b1, 1'b0);
    cyc();
    out_is("idle_hold", 1'b1, 9'h011, 1'b0);
    in0_valid = 1'b0; in1_valid = 1'b0;
`ifdef ARB_STATS_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("cnt0_rst", grant_cnt0, 16'd0);
    check("cnt1_rst", grant_cnt1, 16'd0);
    in0_valid = 1'b1;
    for (int i = 0; i < 70000; i++) cyc();
    in0_valid = 1'b0; in1_valid = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    in1_valid = 1'b0;
    cyc();
    check("cnt0_sat", grant_cnt0, 16'hFFFF);
    check("cnt1", grant_cnt1, 16'd5);
`else
    check("cnt0_off", grant_cnt0, 16'd0);
    check("cnt1_off", grant_cnt1, 16'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/noc_merge_arbiter2.md
Name: noc_merge_arbiter2

Overview:
- Clocked 2-to-1 round-robin merge for NoC flits; the arbitration counterpart to the router's address decoder/splitter.
- Two upstream flit streams (e.g. local inject and a neighbour port) share one downstream link.
- Emits the winning flit through a one-entry output register, plus a 1-bit sideband identifying the granted source.
- Sits at each router output port, ahead of the link toward the next decoder stage.

Parameters:
- W, 9, flit width in bits; [W-1:W-4] is the 4-bit destination address, the rest is payload.
- STAT_W, 16, width of grant counters (used only with ARB_STATS_EN).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in0_valid  in  1  input 0 flit valid
- in0_data  in  W  input 0 flit
- in0_ready  out  1  input 0 flit accepted this cycle
- in1_valid  in  1  input 1 flit valid
- in1_data  in  W  input 1 flit
- in1_ready  out  1  input 1 flit accepted this cycle
- out_valid  out  1  output register holds a flit
- out_data  out  W  registered flit
- out_sel  out  1  source of out_data: 0 = in0, 1 = in1
- out_ready  in  1  downstream accepts out_data this cycle
- grant_cnt0  out  STAT_W  flits forwarded from in0 (ARB_STATS_EN only)
- grant_cnt1  out  STAT_W  flits forwarded from in1 (ARB_STATS_EN only)

Behaviour:
- Reset, sampled at clock edge:
  - out_valid=0, out_data=0, out_sel=0, last_grant=1, so in0 wins the first contention.
  - Any held flit is discarded.
  - in*_ready=0 during the reset cycle.
- Handshakes: a transfer occurs on a cycle with valid&&ready, on both the input side and the output side.
- Stability: valid and data must hold until accepted. out_valid/out_data/out_sel stay stable while out_valid && !out_ready.
- load_en = !out_valid || out_ready. The register is free, or is being drained this same cycle, so a full rate of 1 flit/cycle is sustained.
- Grant (combinational, from current valids and last_grant):
  - only in0_valid → grant 0
  - only in1_valid → grant 1
  - both valid → grant = ~last_grant
  - neither valid → no grant
- in0_ready = load_en && grant==0 && in0_valid. in1_ready follows the same rule with grant==1. At most one ready is high per cycle.
- On an accepted input:
  - next cycle out_valid=1, out_data=flit, out_sel=grant
  - last_grant <= grant
  - latency is exactly 1 cycle, input accept to out_valid
- On load_en with no input valid: if out_ready drained the register, out_valid <= 0. last_grant is unchanged.
- last_grant updates only on an accepted flit. Idle cycles and downstream stalls never rotate priority.
- Stall: while out_valid && !out_ready, both in*_ready=0 and the register holds.
- Data is forwarded unmodified; no address interpretation.
- Contention fairness: with both inputs continuously valid and out_ready=1, grants alternate 0,1,0,1…

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - grant_cnt0/grant_cnt1 increment on each accepted flit from the respective input.
  - Counters saturate at 2^STAT_W-1 (no wrap) and reset to 0.
  - Increment happens on the input-accept edge.
- Undefined:
  - Counter logic is not built; both count ports are tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset mid-stream: out_valid=1 holding 9'h1A5 with out_ready=0, assert reset one cycle → out_valid=0, out_data=0, out_sel=0; with both inputs then valid, first grant goes to in0.
- Single source: in0 sends 9'h0F3, 9'h121, 9'h1FF back to back with out_ready=1 → the same three flits appear on out_data in order, one cycle later each, out_sel=0, in1_ready never high.
- Contention: both valid continuously (in0=9'h011, in1=9'h1E2), out_ready=1 for 6 cycles → out_sel sequence 0,1,0,1,0,1; each input sees ready every other cycle.
- Backpressure: register full, out_ready=0 for 4 cycles with both inputs valid → out_* stable, both readies 0, last_grant unchanged; on release the next grant is the input opposite the held flit's source.
- Priority hold on idle: in1 wins, then 3 idle cycles, then both valid → in0 granted (pointer not rotated by idle).
- ARB_STATS_EN: 70000 accepted flits from in0, 5 from in1 with STAT_W=16 → grant_cnt0=65535 (saturated), grant_cnt1=5; without the macro both read 0.
